weight_fetch_ctrl: RTL and testbench
====================================

# weight_fetch_ctrl

Sequences weight-tile reads from the on-chip weight memory into the weight FIFO that feeds the systolic array's weight-load path. On a start command it walks every 32x32 weight tile of a W_DIM x W_DIM matrix, in the same x-outer / y-inner order in which the control unit consumes tiles. It issues one memory row read per cycle under credit-based flow control, so the FIFO can never overflow regardless of memory latency.

## Interface
- TILE, 32, rows per tile (fixed; row counter is 5 bits)
- ADDR_W, 13, weight memory row-address width
- MEM_LAT, 1, weight memory read latency in cycles (1..4)
- FIFO_DEPTH, 64, weight FIFO depth in rows; credit counter width is clog2(FIFO_DEPTH+1)
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  begin a fetch job; sampled only in IDLE
- W_DIM_i  in  9  matrix dimension minus 1; tiles per axis NT = (W_DIM_i>>5)+1 (1..16); latched at start
- base_addr_i  in  ADDR_W  first row address of the matrix; latched at start
- fifo_pop_i  in  1  consumer popped one row from the weight FIFO (returns one credit)
- mem_rd_en_o  out  1  weight memory read strobe (registered)
- mem_rd_addr_o  out  ADDR_W  read row address (registered, valid with mem_rd_en_o)
- fifo_wr_en_o  out  1  write strobe to the FIFO; equals mem_rd_en_o delayed MEM_LAT cycles
- tile_x_o, tile_y_o  out  4 each  indices of the tile currently being issued
- tile_issued_o  out  1  one-cycle pulse with the mem_rd_en_o of row 31 of each tile
- busy_o  out  1  high from the cycle after start is accepted until done_o
- done_o  out  1  one-cycle pulse when the last row has been written to the FIFO
- err_o  out  1  sticky credit-underflow flag; cleared on an accepted start

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: all strobes low. start_i=1 → latch W_DIM_i and base_addr_i, clear the counters and err_o, go to FETCH.
- FETCH: each cycle with credits>0, issue one read: mem_rd_en_o=1, mem_rd_addr_o = base + linear row count. The layout is contiguous, so the tile (x,y) base is base + (x*NT+y)*32.
  - Row counter 0..31 wraps to 0 and advances tile_y.
  - tile_y wraps after NT-1 and advances tile_x.
  - After issuing row 31 of tile (NT-1, NT-1), go to DRAIN.
- With credits=0, hold all counters and the address, and keep mem_rd_en_o=0.
- Credits: reset value is FIFO_DEPTH.
  - Issue without pop: -1. Pop without issue: +1. Issue and pop in the same cycle: unchanged.
  - Pop while credits==FIFO_DEPTH: the count stays at FIFO_DEPTH and err_o is set.
- DRAIN: no reads are issued. When the MEM_LAT-deep valid pipeline is empty after the final fifo_wr_en_o, pulse done_o, drop busy_o and return to IDLE.
- Credits persist across jobs; fifo_pop_i is honoured in every state.
- start_i in FETCH or DRAIN is ignored.
- Arithmetic: the linear count is ADDR_W bits and the address wraps modulo 2^ADDR_W. The total rows issued per job is NT*NT*32, from 32 to 8192.

## Timing
- Reset values:
  - state IDLE; credits FIFO_DEPTH; all counters 0.
  - mem_rd_en_o, fifo_wr_en_o, tile_issued_o, busy_o, done_o and err_o are all 0.
  - mem_rd_addr_o, tile_x_o and tile_y_o are 0.
  - The valid pipeline is cleared.
- Reset asserted mid-job aborts immediately. Reads still in flight are dropped, with no fifo_wr_en_o after reset.
- start_i sampled high in cycle 0 → busy_o=1 and the first mem_rd_en_o (address base) in cycle 1, provided credits>0.
- Steady state: one row per cycle while credits are available.
- fifo_wr_en_o for a read issued in cycle t is asserted in cycle t+MEM_LAT.
- done_o is asserted in the cycle after the final fifo_wr_en_o. busy_o falls in that same cycle.
- A new start_i is accepted no earlier than the cycle after done_o.
- tile_x_o and tile_y_o update in the cycle after tile_issued_o.

## Test plan
- Reset, W_DIM_i=31, base=0x100, fifo_pop_i held high → reads 0x100..0x11F in cycles 1..32. fifo_wr_en_o in cycles 2..33, done_o in cycle 34. One tile_issued_o pulse, in cycle 32.
- W_DIM_i=63 (NT=2), base=0, continuous pop → 128 reads at addresses 0..127. The (x,y) sequence is (0,0),(0,1),(1,0),(1,1). tile_issued_o fires at reads 31, 63, 95 and 127.
- No pops, FIFO_DEPTH=64, W_DIM_i=95 → exactly 64 reads, then mem_rd_en_o stays low with the address held at 64. A single pop → exactly one more read, at address 64.
- Issue and pop every cycle with credits=1 → sustained one read per cycle and credits stay at 1. A pop at credits=64 in IDLE → err_o=1, which stays set until the next accepted start clears it.
- Assert rst_i during cycle 10 of a MEM_LAT=3 job → every output is at its reset value on the same edge. No fifo_wr_en_o follows, and credits=64.
- start_i pulsed again during FETCH and DRAIN → ignored. A start_i on the cycle after done_o → a new job begins with its first read one cycle later.

Source files
------------

// File: rtl/weight_fetch_ctrl.sv
`timescale 1ns/1ps
// weight_fetch_ctrl: walks the 32x32 weight tiles of a W_DIM x W_DIM matrix
// (x outer, y inner) and issues one memory row read per cycle. Reads are gated
// by a credit counter so the weight FIFO can never overflow.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start_i; no strobes
// S_FETCH | issuing reads while credits are available
// S_DRAIN | all reads issued; waiting for the read-valid pipeline to empty
module weight_fetch_ctrl #(
  parameter int TILE       = 32,
  parameter int ADDR_W     = 13,
  parameter int MEM_LAT    = 1,
  parameter int FIFO_DEPTH = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [8:0]        W_DIM_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              fifo_pop_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  output logic              fifo_wr_en_o,
  output logic [3:0]        tile_x_o,
  output logic [3:0]        tile_y_o,
  output logic              tile_issued_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_DEPTH);
  localparam logic [4:0] ROW_LAST = 5'(TILE - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CRED_W-1:0]   credits_q;
  logic [4:0]          row_q;
  logic [3:0]          x_q, y_q, nt_m1_q;
  logic [ADDR_W-1:0]   base_q, lin_q;
  logic [MEM_LAT-1:0]  vld_q;

  // Effective job values: on the accepting cycle the counters are treated as
  // cleared and the job parameters come straight from the inputs, so the
  // first read goes out in the cycle after start_i.
  logic                accept, issue, last_read, pop_err;
  logic [4:0]          row_eff;
  logic [3:0]          x_eff, y_eff, nt_eff;
  logic [ADDR_W-1:0]   base_eff, lin_eff;
  logic                unused_wdim_lsbs;

  assign unused_wdim_lsbs = ^W_DIM_i[4:0];
  assign fifo_wr_en_o     = vld_q[MEM_LAT-1];

  // Next-state, issue decision and status outputs.
  always_comb begin
    accept    = (state_q == S_IDLE) && start_i;
    row_eff   = accept ? 5'd0 : row_q;
    x_eff     = accept ? 4'd0 : x_q;
    y_eff     = accept ? 4'd0 : y_q;
    nt_eff    = accept ? W_DIM_i[8:5] : nt_m1_q;
    base_eff  = accept ? base_addr_i : base_q;
    lin_eff   = accept ? '0 : lin_q;
    issue     = (accept || (state_q == S_FETCH)) && (credits_q != '0);
    last_read = issue && (row_eff == ROW_LAST) && (x_eff == nt_eff) && (y_eff == nt_eff);
    pop_err   = fifo_pop_i && !issue && (credits_q == CRED_MAX);
    done_o    = (state_q == S_DRAIN) && !mem_rd_en_o && (vld_q == '0);
    busy_o    = (state_q != S_IDLE) && !done_o;
    state_d   = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_FETCH;
      S_FETCH: if (last_read) state_d = S_DRAIN;
      S_DRAIN: if (done_o)    state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath: tile/row counters, registered read strobe, credits, valid pipe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credits_q     <= CRED_MAX;
      row_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      nt_m1_q       <= '0;
      base_q        <= '0;
      lin_q         <= '0;
      vld_q         <= '0;
      mem_rd_en_o   <= 1'b0;
      mem_rd_addr_o <= '0;
      tile_x_o      <= '0;
      tile_y_o      <= '0;
      tile_issued_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      mem_rd_en_o   <= issue;
      tile_issued_o <= issue && (row_eff == ROW_LAST);
      vld_q[0]      <= mem_rd_en_o;
      for (int i = 1; i < MEM_LAT; i++) vld_q[i] <= vld_q[i-1];

      if (accept) begin
        base_q  <= base_addr_i;
        nt_m1_q <= W_DIM_i[8:5];
        err_o   <= 1'b0;
      end else if (pop_err) begin
        err_o   <= 1'b1;
      end

      // While stalled the address shows the next row to be read.
      if (accept || (state_q == S_FETCH)) mem_rd_addr_o <= base_eff + lin_eff;

      if (issue) begin
        lin_q    <= lin_eff + ADDR_W'(1);
        row_q    <= row_eff + 5'd1;
        tile_x_o <= x_eff;
        tile_y_o <= y_eff;
        x_q      <= x_eff;
        y_q      <= y_eff;
        if (row_eff == ROW_LAST) begin
          if (y_eff == nt_eff) begin
            y_q <= 4'd0;
            x_q <= x_eff + 4'd1;
          end else begin
            y_q <= y_eff + 4'd1;
          end
        end
      end else if (accept) begin
        lin_q <= '0;
        row_q <= '0;
        x_q   <= '0;
        y_q   <= '0;
      end

      case ({issue, fifo_pop_i})
        2'b10:   credits_q <= credits_q - CRED_W'(1);
        2'b01:   if (credits_q != CRED_MAX) credits_q <= credits_q + CRED_W'(1);
        default: credits_q <= credits_q;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
`timescale 1ns/1ps
// Directed bench for weight_fetch_ctrl: a table of whole fetch jobs checked
// against a small address/tile model, plus hand sequences for stalls, error
// flag, ignored starts and mid-job reset (MEM_LAT=3 instance).
module tb_weight_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, fifo_pop_i;
  logic [8:0]  W_DIM_i;
  logic [12:0] base_addr_i;

  logic        rd_en, wr_en, ti, busy, done, err;
  logic [12:0] rd_addr;
  logic [3:0]  tx, ty;
  logic        rd_en3, wr_en3, ti3, busy3, done3, err3;
  logic [12:0] rd_addr3;
  logic [3:0]  tx3, ty3;

  int n_chk = 0;
  int n_err = 0;

  weight_fetch_ctrl #(.MEM_LAT(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .W_DIM_i(W_DIM_i),
    .base_addr_i(base_addr_i), .fifo_pop_i(fifo_pop_i),
    .mem_rd_en_o(rd_en), .mem_rd_addr_o(rd_addr), .fifo_wr_en_o(wr_en),
    .tile_x_o(tx), .tile_y_o(ty), .tile_issued_o(ti), .busy_o(busy),
    .done_o(done), .err_o(err));

  weight_fetch_ctrl #(.MEM_LAT(3)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .W_DIM_i(W_DIM_i),
    .base_addr_i(base_addr_i), .fifo_pop_i(fifo_pop_i),
    .mem_rd_en_o(rd_en3), .mem_rd_addr_o(rd_addr3), .fifo_wr_en_o(wr_en3),
    .tile_x_o(tx3), .tile_y_o(ty3), .tile_issued_o(ti3), .busy_o(busy3),
    .done_o(done3), .err_o(err3));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    start_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic [8:0]  wd;
    logic [12:0] ba;
    int          rd;
    int          tis;
    int          done_c;
  } job_t;

  job_t jobs[5];

  // Runs one job starting in the current cycle (cycle 0) with pop held high.
  task automatic run_job(input logic [8:0] wd, input logic [12:0] ba,
                         output int n_rd, output int n_wr, output int n_ti,
                         output int done_c, output int first_c,
                         output int seq_err, output int busy_err);
    int          nt, tile, cyc;
    logic [12:0] ea;
    logic        exp_b;
    nt = int'(wd[8:5]) + 1;
    n_rd = 0; n_wr = 0; n_ti = 0; done_c = -1; first_c = -1;
    seq_err = 0; busy_err = 0; cyc = 0;
    start_i = 1'b1; W_DIM_i = wd; base_addr_i = ba;
    while (cyc < 9000 && done_c < 0) begin
      @(negedge clk_i);
      if (rd_en) begin
        tile = n_rd / 32;
        ea   = ba + 13'(n_rd);
        if (first_c < 0) first_c = cyc;
        if (rd_addr !== ea || tx !== 4'(tile / nt) || ty !== 4'(tile % nt) ||
            ti !== ((n_rd % 32) == 31)) seq_err++;
        n_rd++;
      end
      if (wr_en) n_wr++;
      if (ti) n_ti++;
      exp_b = (cyc != 0) && !done;
      if (busy !== exp_b) busy_err++;
      if (done) done_c = cyc;
      tick();
      start_i = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int rd, done_c, ok_en, ok_cr, bad, n_wr, n_ti, first_c, seq_err, busy_err;
    logic [12:0] last_a;

    jobs[0] = '{wd: 9'd31,  ba: 13'h100,  rd: 32,   tis: 1,   done_c: 34};
    jobs[1] = '{wd: 9'd63,  ba: 13'h000,  rd: 128,  tis: 4,   done_c: 130};
    jobs[2] = '{wd: 9'd95,  ba: 13'h040,  rd: 288,  tis: 9,   done_c: 290};
    jobs[3] = '{wd: 9'd31,  ba: 13'h1FF0, rd: 32,   tis: 1,   done_c: 34};
    jobs[4] = '{wd: 9'd511, ba: 13'h0005, rd: 8192, tis: 256, done_c: 8194};

    rst_i = 1'b1; start_i = 1'b0; fifo_pop_i = 1'b0;
    W_DIM_i = '0; base_addr_i = '0;
    tick();
    tick();
    @(negedge clk_i);
    chk("reset_strobes", {rd_en, wr_en, ti, busy, done, err}, 6'b0);
    chk("reset_addr", rd_addr, 13'h0);
    chk("reset_tile", {tx, ty}, 8'h0);
    chk("reset_credits", dut.credits_q, 64);
    tick();
    rst_i = 1'b0;

    // Pop at full credits in IDLE sets err; accepted start clears it.
    tick();
    fifo_pop_i = 1'b1;
    tick();
    fifo_pop_i = 1'b0;
    @(negedge clk_i);
    chk("err_set_on_overpop", err, 1'b1);
    chk("credits_saturate", dut.credits_q, 64);
    repeat (5) tick();
    @(negedge clk_i);
    chk("err_sticky", err, 1'b1);
    tick();

    // Starts in FETCH/DRAIN ignored; start the cycle after done accepted.
    start_i = 1'b1; W_DIM_i = 9'd31; base_addr_i = 13'h200;
    rd = 0; done_c = -1;
    for (int c = 0; c <= 36; c++) begin
      @(negedge clk_i);
      if (c == 1) chk("err_clear_on_start", err, 1'b0);
      if (c == 20) chk("addr_mid_job", rd_addr, 13'h213);
      if (c == 36) begin
        chk("restart_rd_en", rd_en, 1'b1);
        chk("restart_addr", rd_addr, 13'h300);
      end else if (rd_en) rd++;
      if (done && done_c < 0) done_c = c;
      tick();
      start_i = (c + 1 == 5) || (c + 1 == 33) || (c + 1 == 35);
      if (c + 1 == 5) begin
        base_addr_i = 13'h300;
        W_DIM_i     = 9'd63;
      end
    end
    start_i = 1'b0;
    chk("ignored_start_reads", rd, 32);
    chk("ignored_start_done_cycle", done_c, 34);

    // Credit stall: no pops, 64 reads then hold at the next address.
    do_reset();
    fifo_pop_i = 1'b0; start_i = 1'b1; W_DIM_i = 9'd95; base_addr_i = 13'h0;
    rd = 0; last_a = '0;
    for (int c = 0; c <= 80; c++) begin
      @(negedge clk_i);
      if (rd_en) begin
        rd++;
        last_a = rd_addr;
      end
      tick();
      start_i = 1'b0;
    end
    chk("stall_read_count", rd, 64);
    chk("stall_last_addr", last_a, 13'd63);
    @(negedge clk_i);
    chk("stall_rd_en_low", rd_en, 1'b0);
    chk("stall_addr_held", rd_addr, 13'd64);
    chk("stall_credits", dut.credits_q, 0);
    tick();
    fifo_pop_i = 1'b1;
    tick();
    fifo_pop_i = 1'b0;
    rd = 0; last_a = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (rd_en) begin
        rd++;
        last_a = rd_addr;
      end
      tick();
    end
    chk("one_pop_one_read", rd, 1);
    chk("one_pop_read_addr", last_a, 13'd64);

    // Credits=1 with issue and pop every cycle.
    fifo_pop_i = 1'b1;
    tick();
    tick();
    ok_en = 0; ok_cr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (rd_en) ok_en++;
      if (dut.credits_q == 7'd1) ok_cr++;
      tick();
    end
    chk("credit1_sustained_reads", ok_en, 20);
    chk("credit1_credits_steady", ok_cr, 20);

    // MEM_LAT=3: latency, then reset mid-job in cycle 10.
    do_reset();
    fifo_pop_i = 1'b1; start_i = 1'b1; W_DIM_i = 9'd31; base_addr_i = 13'h080;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk_i);
      if (c == 1) chk("lat3_first_read", {rd_en3, rd_addr3}, {1'b1, 13'h080});
      if (c == 3) chk("lat3_wr_not_early", wr_en3, 1'b0);
      if (c == 4) chk("lat3_wr_at_t_plus_3", wr_en3, 1'b1);
      tick();
      start_i = 1'b0;
    end
    #1;
    rst_i = 1'b1;
    #1;
    chk("midjob_reset_strobes", {rd_en3, wr_en3, ti3, busy3, done3, err3}, 6'b0);
    chk("midjob_reset_addr_tile", {rd_addr3, tx3, ty3}, 21'h0);
    chk("midjob_reset_credits", dut3.credits_q, 64);
    tick();
    rst_i = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (wr_en3 || rd_en3 || busy3) bad++;
      tick();
    end
    chk("midjob_reset_no_late_writes", bad, 0);

    // Table of whole jobs with continuous pop.
    do_reset();
    fifo_pop_i = 1'b1;
    tick();
    for (int j = 0; j < 5; j++) begin
      run_job(jobs[j].wd, jobs[j].ba, rd, n_wr, n_ti, done_c, first_c, seq_err, busy_err);
      chk($sformatf("job%0d_reads", j), rd, jobs[j].rd);
      chk($sformatf("job%0d_fifo_writes", j), n_wr, jobs[j].rd);
      chk($sformatf("job%0d_tile_issued", j), n_ti, jobs[j].tis);
      chk($sformatf("job%0d_done_cycle", j), done_c, jobs[j].done_c);
      chk($sformatf("job%0d_first_read_cycle", j), first_c, 1);
      chk($sformatf("job%0d_addr_tile_seq_errs", j), seq_err, 0);
      chk($sformatf("job%0d_busy_errs", j), busy_err, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
